// File: rtl/dac_seq_pkg.sv
// Shared types and default widths for the DAC update sequencer.
package dac_seq_pkg;
  localparam int CH_BITS_DEF = 3;
  localparam int DATA_W_DEF  = 12;
  localparam int NUM_CH      = 2**CH_BITS_DEF;

  typedef enum logic [2:0] {BOOT, IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} seq_state_e;
endpackage

// File: rtl/dac_rr_pick.sv
// Round-robin picker: first set bit of pend at or after ptr, wrapping.
module dac_rr_pick #(
  parameter int CH_BITS = 3
) (
  input  logic [2**CH_BITS-1:0] pend,
  input  logic [CH_BITS-1:0]    ptr,
  output logic                  vld,
  output logic [CH_BITS-1:0]    idx
);
  localparam int N = 2**CH_BITS;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    vld = 1'b0;
    idx = ptr;
    for (int i = N-1; i >= 0; i--) begin
      if (pend[ptr + CH_BITS'(i)]) begin
        vld = 1'b1;
        idx = ptr + CH_BITS'(i);
      end
    end
  end
endmodule

// File: rtl/dac_sequencer.sv
// Shadow register file + dirty tracking feeding an SPI DAC one channel at a time.
module dac_sequencer
  import dac_seq_pkg::*;
#(
  parameter int CH_BITS        = CH_BITS_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REFRESH_CYCLES = 0,
  parameter int BUSY_TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CH_BITS-1:0]    wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  dac_idle,
  output logic [CH_BITS-1:0]    dac_address,
  output logic [DATA_W-1:0]     dac_value,
  output logic                  dac_trigger,
  output logic                  busy,
  output logic [2**CH_BITS-1:0] pending,
  output logic                  err
);
  localparam int N  = 2**CH_BITS;
  localparam int TW = $clog2(BUSY_TIMEOUT+1);

  seq_state_e               state, state_nx;
  logic [N-1:0][DATA_W-1:0] shadow;
  logic [CH_BITS-1:0]       ptr, pick_idx;
  logic                     pick_vld;
  logic [TW-1:0]            tcnt, tcnt_nx;
  logic                     boot_q;
  logic                     refresh_wrap;
  logic                     load, timeout, done;
  logic [N-1:0]             set_vec, clr_vec;

  dac_rr_pick #(.CH_BITS(CH_BITS)) u_pick (
    .pend (pending),
    .ptr  (ptr),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  generate
    if (REFRESH_CYCLES > 0) begin : g_ref
      localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      logic [RW-1:0] rcnt;
      assign refresh_wrap = (rcnt == RW'(REFRESH_CYCLES-1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rcnt <= '0;
        else if (refresh_wrap) rcnt <= '0;
        else                   rcnt <= rcnt + 1'b1;
      end
    end else begin : g_noref
      assign refresh_wrap = 1'b0;
    end
  endgenerate

  // Timeout counter starts at launch so err lands BUSY_TIMEOUT clk after the trigger.
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    load     = 1'b0;
    timeout  = 1'b0;
    done     = 1'b0;
    case (state)
      BOOT:      if (dac_idle && boot_q) state_nx = IDLE;
      IDLE:      if (pick_vld) begin
                   load     = 1'b1;
                   tcnt_nx  = '0;
                   state_nx = LAUNCH;
                 end
      LAUNCH:    begin
                   tcnt_nx  = tcnt + 1'b1;
                   state_nx = WAIT_BUSY;
                 end
      WAIT_BUSY: if (!dac_idle) state_nx = WAIT_DONE;
                 else if (tcnt == TW'(BUSY_TIMEOUT-1)) begin
                   timeout  = 1'b1;
                   state_nx = IDLE;
                 end else tcnt_nx = tcnt + 1'b1;
      WAIT_DONE: if (dac_idle) begin
                   done     = 1'b1;
                   state_nx = IDLE;
                 end
      default:   state_nx = BOOT;
    endcase
  end

  // Sets are applied after clears, so a write/refresh/requeue beats the pick clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (wr_en)        set_vec[wr_addr]     = 1'b1;
    if (timeout)      set_vec[dac_address] = 1'b1;
    if (refresh_wrap) set_vec              = '1;
    if (load)         clr_vec[pick_idx]    = 1'b1;
  end

  assign dac_trigger = (state == LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      tcnt        <= '0;
      boot_q      <= 1'b0;
      ptr         <= '0;
      pending     <= '0;
      dac_address <= '0;
      dac_value   <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state   <= state_nx;
      tcnt    <= tcnt_nx;
      boot_q  <= (state == BOOT) && dac_idle;
      pending <= (pending & ~clr_vec) | set_vec;
      if (load) begin
        dac_address <= pick_idx;
        dac_value   <= shadow[pick_idx];
        busy        <= 1'b1;
      end
      if (timeout || done) busy <= 1'b0;
      if (timeout)         err  <= 1'b1;
      if (done)            ptr  <= dac_address + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     shadow          <= '0;
    else if (wr_en) shadow[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_dac_sequencer.sv
// Bench: behavioural DAC load per instance, scoreboard of expected transfers.
module tb_dac_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, r_rst_n;
  logic        wr_en, r_wr_en;
  logic [2:0]  wr_addr, r_wr_addr;
  logic [11:0] wr_data, r_wr_data;
  logic        dac_idle, r_idle;
  logic [2:0]  dac_address, r_addr;
  logic [11:0] dac_value, r_val;
  logic        dac_trigger, r_trig, busy, r_busy, err, r_err;
  logic [7:0]  pending, r_pend;

  logic dead, init_hold;
  int   dcnt, rdcnt;
  int   total = 0, bad = 0, trig_cnt = 0;

  typedef struct { logic [2:0] a; logic [11:0] v; } exp_t;
  exp_t q[$], rq[$];

  typedef struct { logic [2:0] ch; logic [11:0] d; logic [2:0] ech; logic [11:0] ev; } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  dac_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dac_idle(dac_idle), .dac_address(dac_address), .dac_value(dac_value),
    .dac_trigger(dac_trigger), .busy(busy), .pending(pending), .err(err)
  );

  dac_sequencer #(.REFRESH_CYCLES(2000)) u_ref (
    .clk(clk), .rst_n(r_rst_n), .wr_en(r_wr_en), .wr_addr(r_wr_addr), .wr_data(r_wr_data),
    .dac_idle(r_idle), .dac_address(r_addr), .dac_value(r_val),
    .dac_trigger(r_trig), .busy(r_busy), .pending(r_pend), .err(r_err)
  );

  // DAC load: cs stays high 2 clk after trigger, then low 4 clk.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)           dcnt <= 0;
    else if (dac_trigger) dcnt <= 6;
    else if (dcnt > 0)    dcnt <= dcnt - 1;
  assign dac_idle = dead || (!init_hold && !(dcnt >= 1 && dcnt <= 4));

  always @(posedge clk or negedge r_rst_n)
    if (!r_rst_n)      rdcnt <= 0;
    else if (r_trig)   rdcnt <= 6;
    else if (rdcnt > 0) rdcnt <= rdcnt - 1;
  assign r_idle = !(rdcnt >= 1 && rdcnt <= 4);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Main monitor: pop on trigger, verify address/value hold while cs is low.
  initial begin
    logic       infl = 1'b0;
    logic [2:0] ca = '0;
    logic [11:0] cv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) infl = 1'b0;
      else begin
        if (dac_trigger) begin
          exp_t e;
          trig_cnt++;
          if (q.size() == 0) chk("unexpected_trigger", {29'd0, dac_address}, 32'hFFFF);
          else begin
            e = q.pop_front();
            chk("trig_addr", dac_address, e.a);
            chk("trig_value", dac_value, e.v);
          end
          infl = 1'b1; ca = dac_address; cv = dac_value;
        end else if (infl && !dac_idle) begin
          chk("hold_addr", dac_address, ca);
          chk("hold_value", dac_value, cv);
        end
        if (!busy) infl = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (r_rst_n && r_trig) begin
        exp_t e;
        if (rq.size() == 0) chk("ref_unexpected_trigger", {29'd0, r_addr}, 32'hFFFF);
        else begin
          e = rq.pop_front();
          chk("ref_addr", r_addr, e.a);
          chk("ref_value", r_val, e.v);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while (!(busy == 1'b0 && pending == 8'h00 && q.size() == 0) && n < maxc) begin
      @(negedge clk); n++;
    end
    chk(nm, n < maxc, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; r_rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    r_wr_en = 1'b0; r_wr_addr = '0; r_wr_data = '0; dead = 1'b0; init_hold = 1'b1;
    for (int i = 0; i < 8; i++) rq.push_back('{a: 3'(i), v: 12'h000});
    tbl[0] = '{ch: 3'd3, d: 12'h333, ech: 3'd3, ev: 12'h333};
    tbl[1] = '{ch: 3'd7, d: 12'h777, ech: 3'd5, ev: 12'h555};
    tbl[2] = '{ch: 3'd0, d: 12'h0F0, ech: 3'd7, ev: 12'h777};
    tbl[3] = '{ch: 3'd5, d: 12'h555, ech: 3'd0, ev: 12'h0F0};

    repeat (3) @(negedge clk);
    chk("rst_addr", dac_address, 0);
    chk("rst_value", dac_value, 0);
    chk("rst_trigger", dac_trigger, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1; r_rst_n = 1'b1;

    // 1: write during DAC init, nothing launches until cs has been high for 2 clk
    repeat (3) @(negedge clk);
    q.push_back('{a: 3'd3, v: 12'hABC});
    wr(3'd3, 12'hABC);
    repeat (6) @(negedge clk);
    chk("boot_no_trigger", trig_cnt, 0);
    chk("boot_pending", pending, 8'h08);
    init_hold = 1'b0;
    drain("t1_drain", 100);
    chk("t1_one_trigger", trig_cnt, 1);
    chk("t1_pending_clear", pending, 0);

    // 2: ch3 in flight while 7,0,5 queue up; pointer lands on 4 -> 5,7,0
    for (int i = 0; i < 4; i++) q.push_back('{a: tbl[i].ech, v: tbl[i].ev});
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = tbl[i].ch; wr_data = tbl[i].d;
      @(negedge clk);
    end
    wr_en = 1'b0;
    drain("t2_drain", 200);

    // 3: second write lands on the pick cycle; set wins, both values go out
    q.push_back('{a: 3'd2, v: 12'h111});
    q.push_back('{a: 3'd2, v: 12'h222});
    wr(3'd2, 12'h111);
    wr(3'd2, 12'h222);
    drain("t3_drain", 200);
    chk("t3_pending", pending, 0);

    // 5: dead DAC -> timeout, requeue, retry once the DAC recovers
    dead = 1'b1;
    q.push_back('{a: 3'd1, v: 12'h1A1});
    q.push_back('{a: 3'd1, v: 12'h1A1});
    wr(3'd1, 12'h1A1);
    n = 0;
    while (!dac_trigger && n < 20) begin @(negedge clk); n++; end
    chk("t5_trigger_seen", n < 20, 1);
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    chk("t5_err_latency", n, 16);
    chk("t5_requeued", pending[1], 1);
    chk("t5_busy_dropped", busy, 0);
    dead = 1'b0;
    drain("t5_retry_drain", 100);
    chk("t5_err_sticky", err, 1);

    // 6: async reset in WAIT_DONE, then BOOT again
    q.push_back('{a: 3'd6, v: 12'h666});
    wr(3'd6, 12'h666);
    n = 0;
    while (!(busy && !dac_idle) && n < 30) begin @(negedge clk); n++; end
    chk("t6_in_transfer", n < 30, 1);
    @(negedge clk);
    #2 rst_n = 1'b0; init_hold = 1'b1;
    #1;
    chk("t6_addr", dac_address, 0);
    chk("t6_value", dac_value, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_trigger", dac_trigger, 0);
    chk("t6_pending", pending, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = trig_cnt;
    q.push_back('{a: 3'd4, v: 12'h4A4});
    wr(3'd4, 12'h4A4);
    repeat (8) @(negedge clk);
    chk("t6_boot_hold", trig_cnt, n);
    init_hold = 1'b0;
    drain("t6_drain", 100);
    chk("t6_relaunch", trig_cnt, n + 1);

    // 4: refresh instance, first period ch0..7, second period with merged write on ch3
    n = 0;
    while (rq.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("ref_period1", rq.size(), 0);
    for (int i = 0; i < 8; i++) rq.push_back('{a: 3'(i), v: (i == 3) ? 12'h3C3 : 12'h000});
    n = 0;
    while (!(r_trig && r_addr == 3'd0) && n < 2500) begin @(negedge clk); n++; end
    chk("ref_wrap_seen", n < 2500, 1);
    r_wr_en = 1'b1; r_wr_addr = 3'd3; r_wr_data = 12'h3C3;
    @(negedge clk);
    r_wr_en = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("ref_period2", rq.size(), 0);
    repeat (60) @(negedge clk);
    chk("ref_pending", r_pend, 0);
    chk("ref_err", r_err, 0);
    chk("main_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
